// File: rtl/ws281x_pkg.sv
// Shared types and helpers for the WS281x line receiver.
package ws281x_pkg;

    localparam int unsigned WordWidth = 24;

    typedef enum logic [1:0] {
        WAIT_RESET,
        IDLE,
        HIGH,
        LOW
    } ws281x_rx_state_e;

    function automatic int unsigned ns_to_cycles(input longint unsigned clk_freq,
                                                 input longint unsigned ns);
        return 32'((clk_freq / 64'd1000) * ns / 64'd1_000_000);
    endfunction

endpackage

// File: rtl/ws281x_rx_fifo.sv
// Word FIFO for the WS281x receiver: power-of-two depth, registered storage, flush.
module ws281x_rx_fifo
    import ws281x_pkg::*;
#(
    parameter int unsigned Depth = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 flush_i,
    input  logic                 push_i,
    input  logic [WordWidth-1:0] wdata_i,
    input  logic                 pop_i,
    output logic [WordWidth-1:0] rdata_o,
    output logic                 valid_o,
    output logic                 full_o
);
    localparam int unsigned AW = $clog2(Depth);

    logic [Depth-1:0][WordWidth-1:0] mem_q;
    logic [AW-1:0]                   wptr_q, rptr_q;
    logic [AW:0]                     cnt_q;
    logic                            do_push, do_pop;

    assign valid_o = (cnt_q != '0);
    assign full_o  = (cnt_q == (AW+1)'(Depth));
    assign rdata_o = mem_q[rptr_q];
    assign do_pop  = pop_i & valid_o;
    // A pop frees the slot in the same cycle, so a full FIFO still accepts.
    assign do_push = push_i & (~full_o | do_pop);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mem_q  <= '0;
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else if (flush_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wptr_q] <= wdata_i;
                wptr_q        <= wptr_q + 1'b1;
            end
            if (do_pop) rptr_q <= rptr_q + 1'b1;
            cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

endmodule

// File: rtl/ws281x_rx.sv
// WS281x single-wire receiver: pulse-width decode into 24-bit GRB words.
// WS281X_RX_FIFO_EN selects a FifoDepth-entry FIFO; otherwise a single holding register.
module ws281x_rx
    import ws281x_pkg::*;
#(
    parameter int unsigned ClkFreq     = 38_000_000,
    parameter int unsigned BitThreshNs = 600,
    parameter int unsigned MaxHighNs   = 2000,
    parameter int unsigned ResetNs     = 50_000,
    parameter int unsigned FifoDepth   = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 enable_i,
    input  logic                 din_i,
    output logic [WordWidth-1:0] data_o,
    output logic                 valid_o,
    input  logic                 ready_i,
    output logic                 latch_o,
    output logic                 frame_err_o,
    output logic                 overflow_o,
    output logic                 busy_o
);
    localparam int unsigned ThreshCyc  = ns_to_cycles(64'(ClkFreq), 64'(BitThreshNs));
    localparam int unsigned MaxHighCyc = ns_to_cycles(64'(ClkFreq), 64'(MaxHighNs));
    localparam int unsigned ResetCyc   = ns_to_cycles(64'(ClkFreq), 64'(ResetNs));
    localparam int unsigned CntW       = $clog2(ResetCyc + 1);

    if (FifoDepth < 2 || (FifoDepth & (FifoDepth - 1)) != 0) begin : g_bad_depth
        $error("FifoDepth must be a power of two >= 2");
    end

    // [1:0] is the two-flop synchronizer, [2] holds the previous synced level.
    logic [2:0] sync_q;
    logic       line, rise, fall;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) sync_q <= '0;
        else         sync_q <= {sync_q[1:0], din_i};
    end

    assign line = sync_q[1];
    assign rise = sync_q[1] & ~sync_q[2];
    assign fall = ~sync_q[1] & sync_q[2];

    ws281x_rx_state_e     state_q;
    logic [CntW-1:0]      cnt_q, cnt_inc;
    logic [4:0]           bitcnt_q;
    logic [WordWidth-1:0] shift_q;
    logic                 push_q, latch_q, ferr_q, ovf_q;
    logic                 bit_val, pop, full;

    assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
    assign bit_val = (cnt_q >= CntW'(ThreshCyc));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= WAIT_RESET;
            cnt_q    <= '0;
            bitcnt_q <= '0;
            shift_q  <= '0;
            push_q   <= 1'b0;
            latch_q  <= 1'b0;
            ferr_q   <= 1'b0;
        end else begin
            push_q  <= 1'b0;
            latch_q <= 1'b0;
            ferr_q  <= 1'b0;
            if (!enable_i) begin
                state_q  <= WAIT_RESET;
                cnt_q    <= '0;
                bitcnt_q <= '0;
                shift_q  <= '0;
            end else begin
                case (state_q)
                    WAIT_RESET: begin
                        if (line)                          cnt_q <= '0;
                        else if (cnt_q >= CntW'(ResetCyc)) begin
                            state_q <= IDLE;
                            cnt_q   <= '0;
                        end else                           cnt_q <= cnt_inc;
                    end
                    IDLE: begin
                        if (rise) begin
                            state_q <= HIGH;
                            cnt_q   <= CntW'(1);
                        end
                    end
                    HIGH: begin
                        if (fall) begin
                            shift_q <= {shift_q[WordWidth-2:0], bit_val};
                            if (bitcnt_q == 5'(WordWidth - 1)) begin
                                push_q   <= 1'b1;
                                bitcnt_q <= '0;
                            end else begin
                                bitcnt_q <= bitcnt_q + 1'b1;
                            end
                            state_q <= LOW;
                            cnt_q   <= CntW'(1);
                        end else if (cnt_q > CntW'(MaxHighCyc)) begin
                            ferr_q   <= 1'b1;
                            state_q  <= WAIT_RESET;
                            cnt_q    <= '0;
                            bitcnt_q <= '0;
                            shift_q  <= '0;
                        end else begin
                            cnt_q <= cnt_inc;
                        end
                    end
                    LOW: begin
                        if (rise) begin
                            state_q <= HIGH;
                            cnt_q   <= CntW'(1);
                        end else if (cnt_q >= CntW'(ResetCyc)) begin
                            latch_q  <= 1'b1;
                            ferr_q   <= (bitcnt_q != '0);
                            bitcnt_q <= '0;
                            shift_q  <= '0;
                            state_q  <= IDLE;
                            cnt_q    <= '0;
                        end else begin
                            cnt_q <= cnt_inc;
                        end
                    end
                    default: state_q <= WAIT_RESET;
                endcase
            end
        end
    end

    // shift_q still holds the completed word in the cycle push_q is high.
    assign pop = valid_o & ready_i;

`ifdef WS281X_RX_FIFO_EN
    ws281x_rx_fifo #(.Depth(FifoDepth)) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .flush_i (~enable_i),
        .push_i  (push_q),
        .wdata_i (shift_q),
        .pop_i   (pop),
        .rdata_o (data_o),
        .valid_o (valid_o),
        .full_o  (full)
    );
`else
    logic [WordWidth-1:0] hold_q;
    logic                 hold_vld_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            hold_q     <= '0;
            hold_vld_q <= 1'b0;
        end else if (!enable_i) begin
            hold_vld_q <= 1'b0;
        end else if (push_q && (!hold_vld_q || pop)) begin
            hold_q     <= shift_q;
            hold_vld_q <= 1'b1;
        end else if (pop) begin
            hold_vld_q <= 1'b0;
        end
    end

    assign data_o  = hold_q;
    assign valid_o = hold_vld_q;
    assign full    = hold_vld_q;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) ovf_q <= 1'b0;
        else         ovf_q <= enable_i & push_q & full & ~pop;
    end

    assign latch_o     = latch_q;
    assign frame_err_o = ferr_q;
    assign overflow_o  = ovf_q;
    assign busy_o      = (state_q == HIGH) || (state_q == LOW && bitcnt_q != '0);

endmodule

// File: tb/tb_ws281x_rx.sv
// Directed bench for ws281x_rx at default parameters (38 MHz clock).
module tb_ws281x_rx;

`ifdef WS281X_RX_FIFO_EN
    localparam int Dep = 4;
`else
    localparam int Dep = 1;
`endif

    logic        clk = 1'b0;
    logic        rst_n, en, din, ready;
    logic [23:0] data;
    logic        valid, latch, ferr, ovf, busy;

    always #5 clk = ~clk;

    ws281x_rx dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .enable_i    (en),
        .din_i       (din),
        .data_o      (data),
        .valid_o     (valid),
        .ready_i     (ready),
        .latch_o     (latch),
        .frame_err_o (ferr),
        .overflow_o  (ovf),
        .busy_o      (busy)
    );

    int          cyc = 0;
    int          n_lat = 0, n_ferr = 0, n_ovf = 0;
    int          lat_cyc = 0, ferr_cyc = 0, vrise_cyc = 0;
    logic        vprev = 1'b0;
    logic [23:0] got_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst_n) begin
            if (valid && ready) got_q.push_back(data);
            if (latch) begin n_lat <= n_lat + 1; lat_cyc <= cyc; end
            if (ferr) begin n_ferr <= n_ferr + 1; ferr_cyc <= cyc; end
            if (ovf) n_ovf <= n_ovf + 1;
            if (valid && !vprev) vrise_cyc <= cyc;
        end
        vprev <= valid;
    end

    int n_chk = 0, n_err = 0;
    int fall_cyc;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    // 1 = hi1 high, 0 = hi0 high; each bit period is 48 cycles where possible.
    task automatic send_word(input logic [23:0] w, input int hi1, input int hi0, input bit pp);
        int hi, lo;
        for (int i = 23; i >= 0; i--) begin
            hi = w[i] ? hi1 : hi0;
            lo = (hi < 30) ? 48 - hi : 18;
            din = 1'b1;
            tick(hi);
            din = 1'b0;
            if (i == 0) fall_cyc = cyc;
            if (i == 0 && pp) begin
                // consumer takes the head on the very edge the new word lands
                tick(3); ready = 1'b1; tick(1); ready = 1'b0; tick(lo - 4);
            end else begin
                tick(lo);
            end
        end
    endtask

    typedef struct {
        logic [23:0] word;
        int          hi1, hi0;
        int          exp_words, exp_latch, exp_err;
    } vec_t;

    vec_t        vecs[7];
    logic [23:0] bp_w[5];
    int          w0, l0, e0, o0;

    initial begin
        vecs[0] = '{24'hA53C0F, 30, 15, 1, 1, 0};
        vecs[1] = '{24'hFFFFFF, 22, 21, 1, 1, 0};
        vecs[2] = '{24'h000000, 22, 21, 1, 1, 0};
        vecs[3] = '{24'h5A5A5A, 22, 21, 1, 1, 0};
        vecs[4] = '{24'hC0FFEE, 76,  3, 1, 1, 0};
        vecs[5] = '{24'h7FFFFF, 80, 15, 0, 0, 1};
        vecs[6] = '{24'h123456, 30, 15, 1, 1, 0};
        bp_w    = '{24'h111111, 24'h222222, 24'h333333, 24'h444444, 24'h555555};

        rst_n = 1'b0; en = 1'b1; din = 1'b0; ready = 1'b1;
        tick(3);
        chk("reset_outputs", {data, valid, latch, ferr, ovf, busy}, 0);
        rst_n = 1'b1;
        tick(2000);

        // first word after a reset gap: latency and latch timing
        w0 = got_q.size(); l0 = n_lat; e0 = n_ferr;
        send_word(24'hA53C0F, 30, 15, 0);
        tick(2000);
        chk("t1_words", got_q.size() - w0, 1);
        if (got_q.size() > w0) chk("t1_data", got_q[w0], 24'hA53C0F);
        chk("t1_valid_lat", vrise_cyc - fall_cyc, 4);
        chk("t1_latch_cnt", n_lat - l0, 1);
        chk("t1_latch_lat", lat_cyc - fall_cyc, 1903);
        chk("t1_ferr", n_ferr - e0, 0);

        for (int v = 0; v < 7; v++) begin
            w0 = got_q.size(); l0 = n_lat; e0 = n_ferr;
            send_word(vecs[v].word, vecs[v].hi1, vecs[v].hi0, 0);
            tick(2000);
            chk($sformatf("v%0d_words", v), got_q.size() - w0, vecs[v].exp_words);
            if (vecs[v].exp_words == 1 && got_q.size() > w0)
                chk($sformatf("v%0d_data", v), got_q[w0], vecs[v].word);
            chk($sformatf("v%0d_latch", v), n_lat - l0, vecs[v].exp_latch);
            chk($sformatf("v%0d_ferr", v), n_ferr - e0, vecs[v].exp_err);
        end

        // partial word: 10 bits then a reset gap
        w0 = got_q.size(); l0 = n_lat; e0 = n_ferr;
        for (int i = 0; i < 10; i++) begin
            din = 1'b1; tick(30); din = 1'b0; tick(18);
        end
        tick(2000);
        chk("t3_latch", n_lat - l0, 1);
        chk("t3_ferr", n_ferr - e0, 1);
        chk("t3_same_cycle", lat_cyc - ferr_cyc, 0);
        chk("t3_words", got_q.size() - w0, 0);

        // back-pressure: five words with no consumer
        ready = 1'b0;
        w0 = got_q.size(); o0 = n_ovf;
        for (int i = 0; i < 5; i++) send_word(bp_w[i], 30, 15, 0);
        tick(2000);
        chk("t2_overflow", n_ovf - o0, 5 - Dep);
        ready = 1'b1; tick(10); ready = 1'b0;
        chk("t2_words", got_q.size() - w0, Dep);
        for (int i = 0; i < Dep; i++)
            if (got_q.size() > w0 + i) chk($sformatf("t2_word%0d", i), got_q[w0 + i], bp_w[i]);

        // full store: push and pop on the same edge
        w0 = got_q.size(); o0 = n_ovf;
        for (int i = 0; i < Dep; i++) send_word(bp_w[i], 30, 15, 0);
        send_word(24'hBEEF01, 30, 15, 1);
        tick(2000);
        chk("t6_overflow", n_ovf - o0, 0);
        ready = 1'b1; tick(10); ready = 1'b0;
        chk("t6_words", got_q.size() - w0, Dep + 1);
        for (int i = 0; i < Dep; i++)
            if (got_q.size() > w0 + i) chk($sformatf("t6_word%0d", i), got_q[w0 + i], bp_w[i]);
        if (got_q.size() > w0 + Dep) chk("t6_last", got_q[w0 + Dep], 24'hBEEF01);

        // enable dropped mid-word with words queued
        send_word(24'h0A0A0A, 30, 15, 0);
        send_word(24'h0B0B0B, 30, 15, 0);
        for (int i = 0; i < 5; i++) begin
            din = 1'b1; tick(15); din = 1'b0; tick(33);
        end
        din = 1'b1; tick(10);
        chk("t5_busy_mid", busy, 1);
        chk("t5_valid_before", valid, 1);
        w0 = got_q.size(); l0 = n_lat; e0 = n_ferr; o0 = n_ovf;
        en = 1'b0;
        tick(1);
        chk("t5_valid_next", valid, 0);
        tick(5); din = 1'b0; tick(20); din = 1'b1; tick(30); din = 1'b0; tick(50);
        chk("t5_busy_off", busy, 0);
        en = 1'b1; ready = 1'b1;
        tick(2000);
        chk("t5_no_err", n_ferr - e0, 0);
        chk("t5_no_latch", n_lat - l0, 0);
        chk("t5_no_ovf", n_ovf - o0, 0);
        chk("t5_no_words", got_q.size() - w0, 0);

        // asynchronous reset in the middle of a bit
        ready = 1'b0;
        send_word(24'h0C0C0C, 30, 15, 0);
        for (int i = 0; i < 3; i++) begin
            din = 1'b1; tick(30); din = 1'b0; tick(18);
        end
        din = 1'b1; tick(5);
        chk("t7_valid_before", valid, 1);
        #2 rst_n = 1'b0;
        #1 chk("t7_reset_outputs", {data, valid, latch, ferr, ovf, busy}, 0);
        din = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(2000);
        ready = 1'b1;
        w0 = got_q.size(); l0 = n_lat;
        send_word(24'h0F0F0F, 30, 15, 0);
        tick(2000);
        chk("t7_words", got_q.size() - w0, 1);
        if (got_q.size() > w0) chk("t7_data", got_q[w0], 24'h0F0F0F);
        chk("t7_latch", n_lat - l0, 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
